// File: rtl/barrel_rotate_pipe_if.sv
// Stream interface for barrel_rotate_pipe: operand issue side and result side.
// The operand producer / result consumer uses master; the rotate unit uses slave.
interface barrel_rotate_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned SH_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SH_W-1:0]  in_amt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/barrel_rotate_pipe.sv
// Pipelined rotate/shift unit: stage k applies a 2^k step when amt[k] is set.
// Bubble-collapsing valid/ready pipeline; op, amt and tag travel with the data.
module barrel_rotate_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  barrel_rotate_pipe_if.slave bus
);
  localparam int unsigned SH_W = $clog2(WIDTH);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  logic [SH_W-1:0]  valid_q;
  logic [WIDTH-1:0] data_q [SH_W];
  logic [TAG_W-1:0] tag_q  [SH_W];
  logic [1:0]       op_q   [SH_W];
  logic [SH_W-1:0]  amt_q  [SH_W];

  logic [SH_W:0]    load_en;

  logic [SH_W-1:0]  src_valid;
  logic [WIDTH-1:0] src_data [SH_W];
  logic [TAG_W-1:0] src_tag  [SH_W];
  logic [1:0]       src_op   [SH_W];
  logic [SH_W-1:0]  src_amt  [SH_W];
  logic [WIDTH-1:0] data_d   [SH_W];

  // A stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    load_en = '0;
    load_en[SH_W] = bus.out_ready;
    for (int k = SH_W - 1; k >= 0; k--) begin
      load_en[k] = !valid_q[k] || load_en[k+1];
    end
  end

  // Stage inputs: stage 0 from the issue port, stage k from stage k-1.
  always_comb begin
    src_valid    = '0;
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    src_tag[0]   = bus.in_tag;
    src_op[0]    = bus.in_op;
    src_amt[0]   = bus.in_amt;
    for (int k = 1; k < SH_W; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_tag[k]   = tag_q[k-1];
      src_op[k]    = op_q[k-1];
      src_amt[k]   = amt_q[k-1];
    end
  end

  // Per-stage 2^k step; rotate-right is done directly rather than via WIDTH-amt.
  always_comb begin
    for (int k = 0; k < SH_W; k++) begin
      data_d[k] = src_data[k];
      if (src_amt[k][k]) begin
        case (src_op[k])
          OP_ROL:  data_d[k] = (src_data[k] << (1 << k)) | (src_data[k] >> (WIDTH - (1 << k)));
          OP_ROR:  data_d[k] = (src_data[k] >> (1 << k)) | (src_data[k] << (WIDTH - (1 << k)));
          OP_SHL:  data_d[k] = src_data[k] << (1 << k);
          OP_SHR:  data_d[k] = src_data[k] >> (1 << k);
          default: data_d[k] = src_data[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < SH_W; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
        op_q[k]   <= '0;
        amt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < SH_W; k++) begin
        if (load_en[k]) begin
          valid_q[k] <= src_valid[k];
          data_q[k]  <= data_d[k];
          tag_q[k]   <= src_tag[k];
          op_q[k]    <= src_op[k];
          amt_q[k]   <= src_amt[k];
        end
      end
    end
  end

  assign bus.in_ready  = load_en[0];
  assign bus.out_valid = valid_q[SH_W-1];
  assign bus.out_data  = data_q[SH_W-1];
  assign bus.out_tag   = tag_q[SH_W-1];

  // The last stage's op/amt have no consumer.
  logic unused_last;
  assign unused_last = &{1'b0, op_q[SH_W-1], amt_q[SH_W-1]};
endmodule

// File: tb/tb_barrel_rotate_pipe.sv
// Self-checking bench for barrel_rotate_pipe (WIDTH=32) against a rotate/shift
// reference computed from double-width concatenation and plain shifts.
module tb_barrel_rotate_pipe;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 4;
  localparam int          LAT   = 5;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrel_rotate_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  barrel_rotate_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] ref_model(logic [31:0] d, logic [1:0] op, logic [4:0] amt);
    logic [63:0] t;
    case (op)
      2'd0: begin t = {d, d} << amt; return t[63:32]; end
      2'd1: begin t = {d, d} >> amt; return t[31:0]; end
      2'd2: return d << amt;
      default: return d >> amt;
    endcase
  endfunction

  task automatic drive_cycle(input logic v, input logic [31:0] d, input logic [4:0] a,
                             input logic [1:0] op, input logic [3:0] t, input logic rdy,
                             output logic acc, output logic emit,
                             output logic [31:0] od, output logic [3:0] ot);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_op     = op;
    bus.in_tag    = t;
    bus.out_ready = rdy;
    #1;
    acc  = v && bus.in_ready;
    emit = bus.out_valid && rdy;
    od   = bus.out_data;
    ot   = bus.out_tag;
  endtask

  task automatic run_single(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                            input logic [3:0] t, output logic [31:0] res,
                            output logic [3:0] rt, output int lat);
    logic acc, emit;
    logic [31:0] od;
    logic [3:0] ot;
    lat = -1; res = '0; rt = '0; acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) drive_cycle(1'b1, d, a, op, t, 1'b1, acc, emit, od, ot);
    if (!acc) return;
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b0, '0, '0, '0, '0, 1'b1, acc, emit, od, ot);
      if (emit) begin lat = i; res = od; rt = ot; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0;
    bus.in_op = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    n_tests++; if (bus.out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag got %h want 0", bus.out_tag); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_rol();
    logic [31:0] res; logic [3:0] rt; int lat;
    run_single(32'h80000001, 5'd1, 2'd0, 4'd3, res, rt, lat);
    n_tests++; if (res !== 32'h00000003 || rt !== 4'd3) begin n_fail++; $display("FAIL rol_basic got %h/%h want 00000003/3", res, rt); end
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL rol_latency got %0d want %0d", lat, LAT); end
    run_single(32'h00000001, 5'd6, 2'd0, 4'd9, res, rt, lat);
    n_tests++; if (res !== 32'h00000040) begin n_fail++; $display("FAIL rol_amt6 got %h want 00000040", res); end
    for (int a = 0; a < 32; a++) begin
      run_single(32'hDEADBEEF, 5'(a), 2'd0, 4'(a), res, rt, lat);
      n_tests++;
      if (res !== ref_model(32'hDEADBEEF, 2'd0, 5'(a)) || rt !== 4'(a) || lat !== LAT) begin
        n_fail++; $display("FAIL rol_sweep amt=%0d got %h/%h lat %0d want %h/%h lat %0d",
                           a, res, rt, lat, ref_model(32'hDEADBEEF, 2'd0, 5'(a)), 4'(a), LAT);
      end
    end
  endtask

  task automatic test_ror();
    logic [31:0] res; logic [3:0] rt; int lat;
    run_single(32'h00000001, 5'd31, 2'd1, 4'd1, res, rt, lat);
    n_tests++; if (res !== 32'h00000002) begin n_fail++; $display("FAIL ror_31 got %h want 00000002", res); end
    run_single(32'h12345678, 5'd4, 2'd1, 4'd2, res, rt, lat);
    n_tests++; if (res !== 32'h81234567) begin n_fail++; $display("FAIL ror_4 got %h want 81234567", res); end
  endtask

  task automatic test_shift();
    logic [31:0] res, d; logic [3:0] rt; int lat;
    run_single(32'hFFFFFFFF, 5'd4, 2'd2, 4'd4, res, rt, lat);
    n_tests++; if (res !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL shl_4 got %h want FFFFFFF0", res); end
    run_single(32'hFFFFFFFF, 5'd4, 2'd3, 4'd5, res, rt, lat);
    n_tests++; if (res !== 32'h0FFFFFFF) begin n_fail++; $display("FAIL shr_4 got %h want 0FFFFFFF", res); end
    run_single(32'h80000000, 5'd31, 2'd3, 4'd6, res, rt, lat);
    n_tests++; if (res !== 32'h00000001) begin n_fail++; $display("FAIL shr_31 got %h want 00000001", res); end
    for (int op = 0; op < 4; op++) begin
      d = $urandom;
      run_single(d, 5'd0, 2'(op), 4'(op), res, rt, lat);
      n_tests++; if (res !== d) begin n_fail++; $display("FAIL amt0 op=%0d got %h want %h", op, res, d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [8]; logic [4:0] a [8]; logic [1:0] o [8];
    logic acc, emit, have; logic [31:0] od, held; logic [3:0] ot;
    int nxt, cnt;
    for (int i = 0; i < 8; i++) begin d[i] = $urandom; a[i] = 5'($urandom); o[i] = 2'($urandom); end
    nxt = 0; have = 1'b0; held = '0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(nxt < 8, d[nxt % 8], a[nxt % 8], o[nxt % 8], 4'(nxt), 1'b0, acc, emit, od, ot);
      if (acc) nxt++;
      if (bus.out_valid) begin
        if (!have) begin held = od; have = 1'b1; end
        else begin
          n_tests++; if (od !== held) begin n_fail++; $display("FAIL stall_stable cyc %0d got %h want %h", c, od, held); end
        end
      end
    end
    n_tests++; if (nxt !== 5) begin n_fail++; $display("FAIL full_accepts got %0d want 5", nxt); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", bus.in_ready); end
    n_tests++; if (held !== ref_model(d[0], o[0], a[0])) begin n_fail++; $display("FAIL stall_head got %h want %h", held, ref_model(d[0], o[0], a[0])); end
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 8; c++) begin
      drive_cycle(nxt < 8, d[nxt % 8], a[nxt % 8], o[nxt % 8], 4'(nxt), 1'b1, acc, emit, od, ot);
      if (acc) nxt++;
      if (emit) begin
        n_tests++;
        if (ot !== 4'(cnt) || od !== ref_model(d[cnt], o[cnt], a[cnt])) begin
          n_fail++; $display("FAIL b2b_order idx %0d got %h/%h want %h/%h", cnt, od, ot, ref_model(d[cnt], o[cnt], a[cnt]), 4'(cnt));
        end
        cnt++;
      end
    end
    n_tests++; if (cnt !== 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", cnt); end
  endtask

  task automatic test_throughput();
    exp_t q[$]; exp_t e;
    logic acc, emit; logic [31:0] od, d; logic [4:0] a; logic [1:0] o; logic [3:0] ot;
    int sent, got, first, last;
    sent = 0; got = 0; first = -1; last = -1;
    for (int c = 0; c < 100 && got < 50; c++) begin
      d = $urandom; a = 5'($urandom); o = 2'($urandom);
      drive_cycle(sent < 50, d, a, o, 4'(sent), 1'b1, acc, emit, od, ot);
      if (emit) begin
        e = q.pop_front();
        if (first < 0) first = c;
        last = c; got++;
        n_tests++; if (od !== e.d || ot !== e.t) begin n_fail++; $display("FAIL tput_data got %h/%h want %h/%h", od, ot, e.d, e.t); end
      end
      if (acc) begin q.push_back('{ref_model(d, o, a), 4'(sent)}); sent++; end
    end
    n_tests++; if (got !== 50 || last - first !== 49) begin n_fail++; $display("FAIL tput_rate got %0d results over %0d cycles want 50 over 50", got, last - first + 1); end
  endtask

  task automatic test_random();
    exp_t q[$]; exp_t e;
    logic acc, emit, pend; logic [31:0] od, d; logic [4:0] a; logic [1:0] o; logic [3:0] t, ot;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; pend = 1'b0; d = '0; a = '0; o = '0; t = '0;
    while (got < 10000 && cyc < 60000) begin
      if (!pend && sent < 10000) begin
        d = $urandom; a = 5'($urandom); o = 2'($urandom); t = 4'($urandom); pend = 1'b1;
      end
      drive_cycle(pend && $urandom_range(0, 1) == 1, d, a, o, t, $urandom_range(0, 1) == 1,
                  acc, emit, od, ot);
      if (emit) begin
        n_tests++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rand_extra got %h/%h want none", od, ot); end
        else begin
          e = q.pop_front();
          got++;
          if (od !== e.d || ot !== e.t) begin n_fail++; $display("FAIL rand_data #%0d got %h/%h want %h/%h", got, od, ot, e.d, e.t); end
        end
      end
      if (acc) begin q.push_back('{ref_model(d, o, a), t}); sent++; pend = 1'b0; end
      cyc++;
    end
    n_tests++; if (got !== 10000 || q.size() != 0) begin n_fail++; $display("FAIL rand_count got %0d pending %0d want 10000 pending 0", got, q.size()); end
  endtask

  task automatic test_reset_mid();
    logic acc, emit; logic [31:0] od; logic [3:0] ot;
    int nacc, extra;
    nacc = 0;
    for (int c = 0; c < 10 && nacc < 3; c++) begin
      drive_cycle(1'b1, $urandom, 5'($urandom), 2'($urandom), 4'(c), 1'b0, acc, emit, od, ot);
      if (acc) nacc++;
    end
    for (int c = 0; c < 5; c++) drive_cycle(1'b0, '0, '0, '0, '0, 1'b0, acc, emit, od, ot);
    n_tests++; if (nacc !== 3 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup got %0d accepts out_valid %b want 3 / 1", nacc, bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %b want 0", bus.out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 1", bus.in_ready); end
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b0, '0, '0, '0, '0, 1'b1, acc, emit, od, ot);
      if (bus.out_valid) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL mid_stale got %0d valid cycles want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_rol();
    test_ror();
    test_shift();
    test_back_to_back();
    test_throughput();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
